// File: rtl/hazard_ctrl_if.sv
// Decode/execute hazard signals between the pipeline (master) and hazard_ctrl (slave).
interface hazard_ctrl_if;
    logic [4:0] IdRsAddr;
    logic [4:0] IdRtAddr;
    logic       IdUsesRt;
    logic       IdMULOp;
    logic       IdJump;
    logic       ExMemRead;
    logic [4:0] ExRAddr;
    logic       ExBranchTaken;
    logic       PCWrite;
    logic       IFIDWrite;
    logic       IFIDFlush;
    logic       IDEXBubble;
    logic       MulBusy;
    logic       MulDone;

    modport master (
        output IdRsAddr, IdRtAddr, IdUsesRt, IdMULOp, IdJump,
        output ExMemRead, ExRAddr, ExBranchTaken,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulBusy, MulDone
    );

    modport slave (
        input  IdRsAddr, IdRtAddr, IdUsesRt, IdMULOp, IdJump,
        input  ExMemRead, ExRAddr, ExBranchTaken,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulBusy, MulDone
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Decode-stage interlock: load-use stall, multi-cycle multiply hold, branch/jump flush.
// Define HAZARD_PERF_EN to add the 32-bit StallCycles performance counter port.
//
// state    | meaning
// IDLE     | normal flow; hazards and flushes resolved combinationally
// MUL_BUSY | multiply occupies execute; decode held, bubbles inserted
module hazard_ctrl #(
    parameter int MUL_CYCLES = 4
) (
    input  logic         Clock,
    input  logic         nReset,
    hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]  StallCycles
`endif
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_t     state;
    logic [3:0] mul_cnt;
    logic       mul_busy;
    logic       mul_done;

    logic load_hazard;
    logic mul_issue;
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;

    assign load_hazard = bus.ExMemRead && (bus.ExRAddr != 5'd0) &&
                         ((bus.ExRAddr == bus.IdRsAddr) ||
                          (bus.IdUsesRt && (bus.ExRAddr == bus.IdRtAddr)));

    // A multiply only issues when nothing of higher priority claims the cycle.
    assign mul_issue = (state == IDLE) && bus.IdMULOp && !bus.ExBranchTaken &&
                       !load_hazard && !bus.IdJump;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (state == MUL_BUSY) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (bus.ExBranchTaken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (bus.IdJump) begin
            ifid_flush  = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            mul_cnt  <= 4'd0;
            mul_busy <= 1'b0;
            mul_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_issue) begin
                        state    <= MUL_BUSY;
                        mul_cnt  <= MUL_LOAD;
                        mul_busy <= 1'b1;
                        mul_done <= (MUL_LOAD == 4'd1);
                    end
                end
                MUL_BUSY: begin
                    if (mul_cnt == 4'd1) begin
                        state    <= IDLE;
                        mul_cnt  <= 4'd0;
                        mul_busy <= 1'b0;
                        mul_done <= 1'b0;
                    end else begin
                        mul_cnt  <= mul_cnt - 4'd1;
                        mul_done <= (mul_cnt == 4'd2);
                    end
                end
                default: begin
                    state    <= IDLE;
                    mul_cnt  <= 4'd0;
                    mul_busy <= 1'b0;
                    mul_done <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PCWrite    = pc_write;
    assign bus.IFIDWrite  = ifid_write;
    assign bus.IFIDFlush  = ifid_flush;
    assign bus.IDEXBubble = idex_bubble;
    assign bus.MulBusy    = mul_busy;
    assign bus.MulDone    = mul_done;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            stall_cycles <= 32'd0;
        end else if (!pc_write) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

    assign StallCycles = stall_cycles;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline interlock controller for the decode stage. It detects load-use hazards between the instruction in decode and a load in execute, and holds decode while a multi-cycle multiply is in flight. It also flushes wrong-path instructions on a taken branch or a jump. It drives the PC and IF/ID write enables and the ID/EX bubble insertion; the register file and decoder outputs pass through untouched.

## Interface
- MUL_CYCLES, 4: multiply occupancy in cycles, legal range 2..16.
- Clock  input  1  rising-edge clock.
- nReset  input  1  asynchronous, active-low reset.
- IdRsAddr  input  5  Rs field (Instruction[25:21]) of the instruction in decode.
- IdRtAddr  input  5  Rt field (Instruction[20:16]) of the instruction in decode.
- IdUsesRt  input  1  the instruction in decode reads Rt (R-type or store/branch).
- IdMULOp  input  1  the instruction in decode is a multiply (decoder MULOp).
- IdJump  input  1  the instruction in decode is a jump (decoder Jump).
- ExMemRead  input  1  the instruction in execute is a load.
- ExRAddr  input  5  destination register of the instruction in execute.
- ExBranchTaken  input  1  a branch resolved taken in execute.
- PCWrite  output  1  PC update enable.
- IFIDWrite  output  1  IF/ID register load enable.
- IFIDFlush  output  1  clears IF/ID to NOP on the next edge.
- IDEXBubble  output  1  loads zeroed control (NOP) into ID/EX on the next edge.
- MulBusy  output  1  a multiply occupies execute.
- MulDone  output  1  single-cycle pulse in the last occupancy cycle.

## Operation
- State machine: IDLE, MUL_BUSY. The 4-bit down-counter MulCnt counts occupancy.
- LoadHazard (combinational) = ExMemRead & (ExRAddr != 0) & ((ExRAddr == IdRsAddr) | (IdUsesRt & ExRAddr == IdRtAddr)).
- IDLE priority, highest first:
  1. ExBranchTaken: IFIDFlush=1, IDEXBubble=1, PCWrite=1. IdMULOp and LoadHazard are ignored because decode holds a wrong-path instruction.
  2. LoadHazard: PCWrite=0, IFIDWrite=0, IDEXBubble=1. This lasts one cycle; the hazard clears as the load leaves execute.
  3. IdJump: IFIDFlush=1, PCWrite=1. The jump itself proceeds to execute.
  4. IdMULOp: the multiply issues normally, and the next state is MUL_BUSY with MulCnt=MUL_CYCLES-1.
  5. Otherwise PCWrite=1, IFIDWrite=1, and all other outputs are 0.
- MUL_BUSY:
  - Outputs: PCWrite=0, IFIDWrite=0, IDEXBubble=1, MulBusy=1.
  - MulCnt decrements every cycle.
  - When MulCnt==1, MulDone=1, and the next state is IDLE with MulCnt=0.
- In MUL_BUSY, ExBranchTaken and IdJump are ignored. They are illegal, because execute holds the multiply; the bench asserts they never occur.
- A multiply in decode behind a load hazard stalls first and enters MUL_BUSY only when it actually issues.
- Back-to-back multiplies: the second stays held in decode and issues on the first IDLE cycle.

## Timing
- All stall, flush and bubble outputs are combinational from the state and the current inputs; they are sampled by the pipeline registers on the same edge.
- MulBusy and MulDone are decoded from the registered state and MulCnt only.
- Multiply issue at edge N leads to MulBusy=1 for cycles N+1 .. N+MUL_CYCLES-1. MulDone is 1 in cycle N+MUL_CYCLES-1, and decode is released at cycle N+MUL_CYCLES.
- Stall is exactly MUL_CYCLES-1 cycles per multiply.
- Reset (asynchronous, any cycle, including mid-MUL_BUSY):
  - state=IDLE, MulCnt=0, MulBusy=0, MulDone=0, StallCycles=0.
  - With all inputs 0, PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0.
- Register 0 never causes a hazard.

## Configuration
- HAZARD_PERF_EN defined:
  - Adds output StallCycles (32 bits).
  - It increments in every cycle where PCWrite==0, and wraps from 0xFFFFFFFF to 0.
  - It is reset to 0 by nReset.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
- Load-use: ExMemRead=1, ExRAddr=5, IdRsAddr=5 → one cycle of PCWrite=0, IFIDWrite=0, IDEXBubble=1, then normal flow; ExRAddr=0 with IdRsAddr=0 → no stall.
- Rt gating: ExRAddr=7, IdRtAddr=7, IdUsesRt=0 → no stall; IdUsesRt=1 → one-cycle stall.
- Multiply with MUL_CYCLES=4: IdMULOp=1 for one edge → MulBusy high for 3 cycles, MulDone pulses in the 3rd, PCWrite=0 for exactly 3 cycles.
- Priority: ExBranchTaken=1 together with LoadHazard and IdMULOp → IFIDFlush=1, IDEXBubble=1, PCWrite=1, no MUL_BUSY entry; IdJump alone → IFIDFlush=1, IDEXBubble=0.
- Reset mid-multiply: nReset low in the 2nd MUL_BUSY cycle → MulBusy=0 immediately, PCWrite=1 after release, and the next multiply sees a full MUL_CYCLES-1 stall.
- With HAZARD_PERF_EN: one load stall plus one multiply (MUL_CYCLES=4) → StallCycles=4.
